// File: rtl/operand_entry_fsm.sv
// Two-operand BCD keypad entry controller.
// Collects up to two decimal digits for operand A, then up to two for
// operand B, then holds both for a downstream subtractor while in SHOW_RES.
// Keys are acted on only on the rising edge of key_valid, so a held key
// counts once. Every response is registered and shows one clock after the
// edge on which the key was sampled.
//
// Handshake: key_valid is a level strobe with no back-pressure. A key is
// accepted in the cycle where key_valid is high and was low in the previous
// cycle, with key_code sampled in that same cycle. There is no ready.
// Rejected keys raise entry_err for exactly one cycle.
module operand_entry_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] num_0,
  output logic [3:0] num_1,
  output logic [3:0] num_2,
  output logic [3:0] num_3,
  output logic [1:0] state,
  output logic       result_valid,
  output logic       entry_err
);

  typedef enum logic [1:0] {
    ST_ENTER_A  = 2'b00,
    ST_ENTER_B  = 2'b01,
    ST_SHOW_RES = 2'b10,
    ST_ILLEGAL  = 2'b11
  } state_t;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [1:0] DCNT_MAX  = 2'd2;

  state_t     state_q;
  logic [1:0] dcnt;
  logic       key_valid_d;
  logic       key_press;
  logic       is_digit;
  logic       is_enter;
  logic       is_clear;
  logic       is_unused;

  // Rising-edge detect on the keypad strobe plus key classification.
  always_comb begin
    key_press = key_valid & ~key_valid_d;
    is_digit  = (key_code <= 4'd9);
    is_enter  = (key_code == KEY_ENTER);
    is_clear  = (key_code == KEY_CLEAR);
    is_unused = (key_code >= 4'hC);
  end

  // The encoded state is exposed directly; it doubles as the debug view.
  assign state = state_q;

  // Entry FSM: state, digit registers, digit counter and flags in one place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ENTER_A;
      num_0        <= 4'd0;
      num_1        <= 4'd0;
      num_2        <= 4'd0;
      num_3        <= 4'd0;
      dcnt         <= 2'd0;
      result_valid <= 1'b0;
      entry_err    <= 1'b0;
      key_valid_d  <= 1'b0;
    end else begin
      key_valid_d <= key_valid;
      // entry_err defaults low so it can only ever be a single-cycle pulse.
      entry_err   <= 1'b0;

      if (state_q == ST_ILLEGAL) begin
        // Recover from the unused encoding with a clean, empty entry.
        state_q      <= ST_ENTER_A;
        num_0        <= 4'd0;
        num_1        <= 4'd0;
        num_2        <= 4'd0;
        num_3        <= 4'd0;
        dcnt         <= 2'd0;
        result_valid <= 1'b0;
      end else if (key_press) begin
        if (is_clear) begin
          // CLEAR wipes everything from any state and is never an error.
          state_q      <= ST_ENTER_A;
          num_0        <= 4'd0;
          num_1        <= 4'd0;
          num_2        <= 4'd0;
          num_3        <= 4'd0;
          dcnt         <= 2'd0;
          result_valid <= 1'b0;
        end else if (is_unused) begin
          entry_err <= 1'b1;
        end else if (is_enter) begin
          case (state_q)
            ST_ENTER_A: begin
              // Operand A keeps whatever digits it has; none means zero.
              state_q <= ST_ENTER_B;
              dcnt    <= 2'd0;
            end
            ST_ENTER_B: begin
              state_q      <= ST_SHOW_RES;
              result_valid <= 1'b1;
            end
            default: begin
              // ENTER while showing the result is silently ignored.
            end
          endcase
        end else if (is_digit) begin
          case (state_q)
            ST_ENTER_A: begin
              if (dcnt == DCNT_MAX) begin
                entry_err <= 1'b1;
              end else begin
                num_1 <= num_0;
                num_0 <= key_code;
                dcnt  <= dcnt + 2'd1;
              end
            end
            ST_ENTER_B: begin
              if (dcnt == DCNT_MAX) begin
                entry_err <= 1'b1;
              end else begin
                num_3 <= num_2;
                num_2 <= key_code;
                dcnt  <= dcnt + 2'd1;
              end
            end
            ST_SHOW_RES: begin
              // A digit starts a fresh calculation with that digit as A.
              state_q      <= ST_ENTER_A;
              num_0        <= key_code;
              num_1        <= 4'd0;
              num_2        <= 4'd0;
              num_3        <= 4'd0;
              dcnt         <= 2'd1;
              result_valid <= 1'b0;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/operand_entry_fsm.md
OPERAND_ENTRY_FSM -- requirements
Module: operand_entry_fsm

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: key_valid  input  1  key-press strobe from keypad scanner, may stay high for several cycles.
REQ-004 SHALL have port: key_code  input  4  key value: 0-9 digit, 4'hA ENTER, 4'hB CLEAR, 4'hC-4'hF unused.
REQ-005 SHALL have port: num_0  output  4  BCD ones digit, operand A.
REQ-006 SHALL have port: num_1  output  4  BCD tens digit, operand A.
REQ-007 SHALL have port: num_2  output  4  BCD ones digit, operand B.
REQ-008 SHALL have port: num_3  output  4  BCD tens digit, operand B.
REQ-009 SHALL have port: state  output  2  entry state: 2'b00 ENTER_A, 2'b01 ENTER_B, 2'b10 SHOW_RES.
REQ-010 SHALL have port: result_valid  output  1  high while in SHOW_RES; downstream subtractor output is displayable.
REQ-011 SHALL have port: entry_err  output  1  one-cycle pulse when a key is rejected.

Function
REQ-012 SHALL register key_valid (key_valid_d) and act only on a rising edge, key_press = key_valid & ~key_valid_d; a held key SHALL count once.
REQ-013 SHALL sample key_code in the same cycle as key_press; all responses SHALL be visible one clock after that edge.
REQ-014 SHALL keep a 2-bit digit counter dcnt (0..2) for the operand currently being entered.
REQ-015 In ENTER_A, a digit with dcnt<2 SHALL shift: num_1<=num_0, num_0<=key_code, dcnt<=dcnt+1.
REQ-016 In ENTER_B, a digit with dcnt<2 SHALL shift: num_3<=num_2, num_2<=key_code, dcnt<=dcnt+1.
REQ-017 A digit with dcnt==2 in ENTER_A/ENTER_B SHALL be ignored, digits unchanged, entry_err pulsed one cycle.
REQ-018 ENTER in ENTER_A SHALL go to ENTER_B, dcnt<=0; operand A keeps its digits (zero digits entered means value 0).
REQ-019 ENTER in ENTER_B SHALL go to SHOW_RES; result_valid SHALL be 1 from the next cycle.
REQ-020 In SHOW_RES, all digits SHALL hold; ENTER SHALL be ignored without error.
REQ-021 In SHOW_RES, a digit SHALL clear num_3..num_1 to 0, load num_0<=key_code, set dcnt<=1, go to ENTER_A.
REQ-022 CLEAR in any state SHALL zero num_0..num_3 and dcnt and go to ENTER_A, with no entry_err.
REQ-023 Codes 4'hC-4'hF SHALL be ignored in every state, with a one-cycle entry_err pulse.
REQ-024 Every num_x output SHALL always hold a value 0-9.
REQ-025 Unused state encoding 2'b11 SHALL go to ENTER_A with all digits cleared on the next clock.
REQ-026 entry_err SHALL be registered and SHALL never be high for two consecutive cycles from a single key press.

Reset
REQ-027 With rst=1 at a clock edge: num_0..num_3=0, state=ENTER_A, dcnt=0, result_valid=0, entry_err=0, key_valid_d=0.
REQ-028 rst SHALL take priority over any simultaneous key_press; the key SHALL be dropped.
REQ-029 rst asserted mid-entry or in SHOW_RES SHALL discard all entered digits.
REQ-030 After rst is released with key_valid already high, the first cycle SHALL count as a rising edge (key_valid_d=0).

Verification
REQ-031 After reset, press 4,2,ENTER,1,7,ENTER (each key_valid 3 cycles high, 2 low) -> num_1=4, num_0=2, num_3=1, num_2=7, state=SHOW_RES, result_valid=1.
REQ-032 In ENTER_A, press 9,8,5 -> num_1=9, num_0=8; entry_err pulses exactly once, one cycle after the 5 edge.
REQ-033 key_valid held high 20 cycles with key_code=3 -> a single shift only, num_0=3, dcnt=1.
REQ-034 In SHOW_RES, press 6 -> next cycle num_0=6, num_1=num_2=num_3=0, state=ENTER_A, result_valid=0.
REQ-035 In ENTER_B, press CLEAR -> all digits 0, state=ENTER_A; in ENTER_A press 4'hE -> entry_err pulse, no state change.
REQ-036 Assert rst in the same cycle as a digit edge in ENTER_B -> all outputs at reset values; the digit is not captured.
